// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_NUM_READ   = 2;

    // Bit offset of read port `port` inside a packed bus of `width`-bit fields.
    function automatic int rd_off(input int port, input int width);
        return port * width;
    endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, zero register, write bypass and busy override.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                                        reset,
    input  logic [ADDR_WIDTH-1:0]                       addr,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]    regs,
    input  logic [2**ADDR_WIDTH-1:0]                    busy_vec,
    input  logic                                        we0,
    input  logic [ADDR_WIDTH-1:0]                       wa0,
    input  logic [DATA_WIDTH-1:0]                       wd0,
    input  logic                                        we1,
    input  logic [ADDR_WIDTH-1:0]                       wa1,
    input  logic [DATA_WIDTH-1:0]                       wd1,
    input  logic                                        issue_valid,
    input  logic [ADDR_WIDTH-1:0]                       issue_reg,
    output logic [DATA_WIDTH-1:0]                       data,
    output logic                                        busy_flag
);
    logic issue_hit;

    assign issue_hit = issue_valid && (issue_reg == addr);

    always_comb begin
        data      = regs[addr];
        busy_flag = busy_vec[addr];
        if (BYPASS != 0) begin
            // Port 1 is applied last so it wins a same-address collision.
            if (we0 && (wa0 == addr)) begin
                data      = wd0;
                busy_flag = issue_hit;
            end
            if (we1 && (wa1 == addr)) begin
                data      = wd1;
                busy_flag = issue_hit;
            end
        end
        // Reset must blank reads even while a bypassed write is on the bus.
        if (reset || ((ZERO_REG != 0) && (addr == '0))) begin
            data      = '0;
            busy_flag = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, busy scoreboard and write priority; reads in regfile_read_port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_reg
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0]                 busy;
    logic                             wen0, wen1, iss;

    assign wen0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wen1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign iss  = issue_valid && !((ZERO_REG != 0) && (issue_reg == '0));

    // Statement order encodes priority: port 1 over port 0, issue-set over write-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wen0) begin
                regs[wa0] <= wd0;
                busy[wa0] <= 1'b0;
            end
            if (wen1) begin
                regs[wa1] <= wd1;
                busy[wa1] <= 1'b0;
            end
            if (iss)
                busy[issue_reg] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYPASS     (BYPASS),
            .ZERO_REG   (ZERO_REG)
        ) u_rp (
            .reset       (reset),
            .addr        (rd_addr[rd_off(i, ADDR_WIDTH) +: ADDR_WIDTH]),
            .regs        (regs),
            .busy_vec    (busy),
            .we0         (we0),
            .wa0         (wa0),
            .wd0         (wd0),
            .we1         (we1),
            .wa1         (wa1),
            .wd1         (wd1),
            .issue_valid (issue_valid),
            .issue_reg   (issue_reg),
            .data        (rd_data[rd_off(i, DATA_WIDTH) +: DATA_WIDTH]),
            .busy_flag   (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a bypassing and a non-bypassing regfile_mp driven in parallel.
module tb_regfile_mp;
    logic        clock, reset;
    logic [11:0] rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        we0, we1, issue_valid;
    logic [5:0]  wa0, wa1, issue_reg;
    logic [31:0] wd0, wd1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mreg  [64];
    bit          mbusy [64];

    typedef struct {
        logic we0; logic [5:0] wa0; logic [31:0] wd0;
        logic we1; logic [5:0] wa1; logic [31:0] wd1;
        logic iv;  logic [5:0] ir;
        logic [5:0] ra0, ra1;
        logic [31:0] d0, d1;
        logic b0, b1;
    } vec_t;
    vec_t tbl [10];

    regfile_mp #(.BYPASS(1), .ZERO_REG(1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .issue_valid(issue_valid), .issue_reg(issue_reg));

    regfile_mp #(.BYPASS(0), .ZERO_REG(1)) dut_n (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .issue_valid(issue_valid), .issue_reg(issue_reg));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour straight from the register-file rules.
    function automatic logic [31:0] exp_data(input logic [5:0] a, input bit byp);
        if (a == 0) return 32'd0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [5:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a)))
            return issue_valid && issue_reg == a;
        return mbusy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (we0 && wa0 != 0) begin mreg[wa0] = wd0; mbusy[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin mreg[wa1] = wd1; mbusy[wa1] = 1'b0; end
        if (issue_valid && issue_reg != 0) mbusy[issue_reg] = 1'b1;
    endtask

    task automatic check_model();
        for (int p = 0; p < 2; p++) begin
            logic [5:0] a;
            a = rd_addr[p*6 +: 6];
            chk($sformatf("byp_data p%0d a%0d", p, a), rd_data_b[p*32 +: 32], exp_data(a, 1'b1));
            chk($sformatf("byp_busy p%0d a%0d", p, a), {31'd0, rd_busy_b[p]}, {31'd0, exp_busy(a, 1'b1)});
            chk($sformatf("nob_data p%0d a%0d", p, a), rd_data_n[p*32 +: 32], exp_data(a, 1'b0));
            chk($sformatf("nob_busy p%0d a%0d", p, a), {31'd0, rd_busy_n[p]}, {31'd0, exp_busy(a, 1'b0)});
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        issue_valid = 0; issue_reg = 0;
    endtask

    // Drive one cycle's inputs at the falling edge, check before the rising edge, then advance the model.
    task automatic cycle(input logic e0, input logic [5:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [5:0] a1, input logic [31:0] d1,
                         input logic iv, input logic [5:0] ir,
                         input logic [5:0] r0, input logic [5:0] r1);
        @(negedge clock);
        we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
        issue_valid = iv; issue_reg = ir; rd_addr = {r1, r0};
        #1 check_model();
        @(posedge clock);
        model_edge();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state over every address on both ports.
        for (int a = 0; a < 64; a++) begin
            logic [5:0] x, y;
            x = 6'(a);
            y = 6'(63 - a);
            rd_addr = {y, x};
            #1 check_model();
        end

        // Directed sequence; expected columns are the same-cycle view of the bypassing instance.
        tbl[0] = '{1, 1, 100,          0, 0, 0,   0, 0, 1, 2, 100, 0,   0, 0};
        tbl[1] = '{1, 2, 200,          0, 0, 0,   0, 0, 1, 2, 100, 200, 0, 0};
        tbl[2] = '{1, 0, 32'hDEADBEEF, 0, 0, 0,   1, 0, 0, 1, 0,   100, 0, 0};
        tbl[3] = '{1, 5, 7,            1, 5, 9,   0, 0, 5, 0, 9,   0,   0, 0};
        tbl[4] = '{0, 0, 0,            0, 0, 0,   1, 3, 3, 5, 0,   9,   0, 0};
        tbl[5] = '{0, 0, 0,            0, 0, 0,   0, 0, 3, 5, 0,   9,   1, 0};
        tbl[6] = '{1, 3, 300,          0, 0, 0,   1, 3, 3, 3, 300, 300, 1, 1};
        tbl[7] = '{0, 0, 0,            0, 0, 0,   0, 0, 3, 1, 300, 100, 1, 0};
        tbl[8] = '{0, 0, 0,            1, 3, 301, 0, 0, 3, 3, 301, 301, 0, 0};
        tbl[9] = '{0, 0, 0,            0, 0, 0,   0, 0, 3, 5, 301, 9,   0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            issue_valid = tbl[i].iv; issue_reg = tbl[i].ir;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("tbl%0d d0", i), rd_data_b[31:0],  tbl[i].d0);
            chk($sformatf("tbl%0d d1", i), rd_data_b[63:32], tbl[i].d1);
            chk($sformatf("tbl%0d b0", i), {31'd0, rd_busy_b[0]}, {31'd0, tbl[i].b0});
            chk($sformatf("tbl%0d b1", i), {31'd0, rd_busy_b[1]}, {31'd0, tbl[i].b1});
            check_model();
            @(posedge clock);
            model_edge();
        end

        // Asynchronous reset between edges while reg 7 holds 55 and is busy.
        cycle(1, 7, 55, 0, 0, 0, 0, 0, 7, 7);
        cycle(0, 0, 0,  0, 0, 0, 1, 7, 7, 7);
        @(negedge clock);
        idle();
        rd_addr = {6'd7, 6'd7};
        #1;
        chk("pre_rst data", rd_data_n[31:0], 32'd55);
        chk("pre_rst busy", {31'd0, rd_busy_n[0]}, 32'd1);
        we0 = 1; wa0 = 7; wd0 = 66;
        #1 reset = 1'b1;
        #1;
        chk("rst byp data", rd_data_b[31:0], 32'd0);
        chk("rst byp busy", {31'd0, rd_busy_b[0]}, 32'd0);
        chk("rst nob data", rd_data_n[31:0], 32'd0);
        chk("rst nob busy", {31'd0, rd_busy_n[0]}, 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        chk("post_rst byp data", rd_data_b[31:0], 32'd0);
        chk("post_rst nob data", rd_data_n[31:0], 32'd0);
        // Write on the first edge after release must land.
        cycle(1, 7, 77, 0, 0, 0, 0, 0, 7, 6);
        cycle(0, 0, 0,  0, 0, 0, 0, 0, 7, 6);

        // Randomised traffic over a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
